// File: rtl/conv_job_sequencer.sv
// conv_job_sequencer: synchronises toggle-style start requests, queues them as a count and
// sequences engine jobs with a watchdog, a held result register and sticky error flags.
module conv_job_sequencer #(
    parameter int NUM_FILTERS    = 5,
    parameter int RES_W          = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int QUEUE_DEPTH    = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic                               clk_main,
    input  logic                               rst_main,
    input  logic                               req_toggle_async,
    input  logic                               abort,
    output logic                               eng_start,
    input  logic                               eng_busy,
    input  logic                               eng_done,
    input  logic [NUM_FILTERS*RES_W-1:0]       eng_results,
    output logic [NUM_FILTERS*RES_W-1:0]       results,
    output logic                               results_valid,
    input  logic                               results_ack,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   pending_cnt,
    output logic [CNT_W-1:0]                   jobs_done,
    output logic                               overflow_err,
    output logic                               timeout_err,
    input  logic                               err_clr,
    output logic                               idle
);
    localparam int PW = $clog2(QUEUE_DEPTH + 1);
    localparam int DW = NUM_FILTERS * RES_W;
    localparam int WD_W = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, LATCH} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, vld_q;
    logic                   ref_q, primed_q, req_q;
    logic [PW-1:0]          pend_q, pend_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic [DW-1:0]          cap_q, cap_d, res_q, res_d;
    logic                   rvld_q, rvld_d;
    logic [CNT_W-1:0]       jobs_q, jobs_d;
    logic                   ovf_q, ovf_d, tmo_q, tmo_d;
    logic                   start_q, idle_q;
    logic                   launch, req_ok, full, tmo_evt;

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        cap_d   = cap_q;
        tmo_evt = 1'b0;
        case (state_q)
            IDLE:  state_d = (pend_q != '0 && !rvld_q && !eng_busy) ? ISSUE : IDLE;
            ISSUE: begin
                state_d = WAIT;
                wd_d    = '0;
            end
            WAIT: begin
                if (eng_done) begin
                    cap_d   = eng_results;
                    state_d = LATCH;
                end else if (TIMEOUT_CYCLES != 0 && wd_q == WD_MAX) begin
                    tmo_evt = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            LATCH: state_d = IDLE;
        endcase
        // abort wins over everything in flight, including a coincident request or timeout
        if (abort) begin
            state_d = IDLE;
            wd_d    = '0;
            tmo_evt = 1'b0;
        end
        launch = state_q == ISSUE;
        req_ok = req_q && !abort;
        full   = pend_q == PW'(QUEUE_DEPTH);
        pend_d = abort ? '0 :
                 (req_ok && !launch && !full) ? pend_q + 1'b1 :
                 (launch && !req_ok) ? pend_q - 1'b1 : pend_q;
        res_d  = state_q == LATCH ? cap_q : res_q;
        rvld_d = state_q == LATCH || (rvld_q && !results_ack);
        jobs_d = state_q == LATCH ? jobs_q + 1'b1 : jobs_q;
        ovf_d  = (req_ok && full && !launch) || (ovf_q && !err_clr);
        tmo_d  = tmo_evt || (tmo_q && !err_clr);
    end

    always_ff @(posedge clk_main or posedge rst_main) begin
        if (rst_main) begin
            sync_q   <= '0;
            vld_q    <= '0;
            ref_q    <= 1'b0;
            primed_q <= 1'b0;
            req_q    <= 1'b0;
            state_q  <= IDLE;
            pend_q   <= '0;
            wd_q     <= '0;
            cap_q    <= '0;
            res_q    <= '0;
            rvld_q   <= 1'b0;
            jobs_q   <= '0;
            ovf_q    <= 1'b0;
            tmo_q    <= 1'b0;
            start_q  <= 1'b0;
            idle_q   <= 1'b1;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], req_toggle_async};
            vld_q    <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            // the first valid sample only primes the reference, so a high level at reset release is not a request
            ref_q    <= vld_q[SYNC_STAGES-1] ? sync_q[SYNC_STAGES-1] : ref_q;
            primed_q <= primed_q || vld_q[SYNC_STAGES-1];
            req_q    <= primed_q && (sync_q[SYNC_STAGES-1] != ref_q);
            state_q  <= state_d;
            pend_q   <= pend_d;
            wd_q     <= wd_d;
            cap_q    <= cap_d;
            res_q    <= res_d;
            rvld_q   <= rvld_d;
            jobs_q   <= jobs_d;
            ovf_q    <= ovf_d;
            tmo_q    <= tmo_d;
            start_q  <= state_d == ISSUE;
            idle_q   <= state_d == IDLE && pend_d == '0;
        end
    end

    assign eng_start     = start_q;
    assign results       = res_q;
    assign results_valid = rvld_q;
    assign pending_cnt   = pend_q;
    assign jobs_done     = jobs_q;
    assign overflow_err  = ovf_q;
    assign timeout_err   = tmo_q;
    assign idle          = idle_q;
endmodule

// File: tb/tb_conv_job_sequencer.sv
// tb_conv_job_sequencer: randomized job traffic against a transaction-level model of the
// queue, result stream and error flags, with a small behavioural engine.
module tb_conv_job_sequencer;
    localparam int NF = 5, RW = 16, SS = 2, QD = 4, TO = 16, CW = 16;
    localparam int DW = NF * RW;

    logic clk_main = 0, rst_main = 0, req_toggle_async = 0, abort = 0;
    logic eng_done = 0, results_ack = 0, err_clr = 0;
    logic eng_busy, eng_start, results_valid, overflow_err, timeout_err, idle;
    logic [DW-1:0] eng_results = '0, results;
    logic [2:0] pending_cnt;
    logic [CW-1:0] jobs_done;

    int total = 0, bad = 0, cyc = 0, starts = 0, dly = 0, done_cyc = 0, eng_delay = 10, jobs_exp = 0;
    bit busy_hold = 0, eng_hang = 0, fixed = 0;
    logic [DW-1:0] exp_q[$];

    conv_job_sequencer #(.NUM_FILTERS(NF), .RES_W(RW), .SYNC_STAGES(SS), .QUEUE_DEPTH(QD),
                         .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk_main(clk_main), .rst_main(rst_main), .req_toggle_async(req_toggle_async),
        .abort(abort), .eng_start(eng_start), .eng_busy(eng_busy), .eng_done(eng_done),
        .eng_results(eng_results), .results(results), .results_valid(results_valid),
        .results_ack(results_ack), .pending_cnt(pending_cnt), .jobs_done(jobs_done),
        .overflow_err(overflow_err), .timeout_err(timeout_err), .err_clr(err_clr), .idle(idle));

    always #5 clk_main = ~clk_main;
    always @(posedge clk_main) cyc <= cyc + 1;
    assign eng_busy = busy_hold | (dly != 0);

    // engine: busy for eng_delay cycles after a start, then one done pulse with fresh results
    initial forever begin
        @(posedge clk_main);
        #2;
        eng_done = 0;
        if (eng_start) begin
            starts++;
            dly = eng_delay;
        end else if (dly > 0) begin
            dly--;
            if (dly == 0 && !eng_hang) begin
                for (int f = 0; f < NF; f++) eng_results[f*RW +: RW] = fixed ? RW'(f + 1) : RW'($urandom);
                exp_q.push_back(eng_results);
                eng_done = 1;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_main);
        #1;
    endtask

    task automatic toggle();
        req_toggle_async = ~req_toggle_async;
    endtask

    task automatic wait_start(input int lim, output int n);
        n = 0;
        while (!eng_start && n < lim) begin
            step(1);
            n++;
        end
        chk("eng_start_seen", eng_start, 1);
    endtask

    task automatic wait_valid(input int lim);
        int n = 0;
        while (!results_valid && n < lim) begin
            step(1);
            n++;
        end
        chk("results_valid_seen", results_valid, 1);
    endtask

    task automatic ack();
        results_ack = 1;
        step(1);
        results_ack = 0;
    endtask

    task automatic take_result(input string tag);
        logic [DW-1:0] r;
        r = exp_q.size() != 0 ? exp_q.pop_front() : '1;
        jobs_exp++;
        chk(tag, results, r);
        chk({tag, "_jobs"}, jobs_done, jobs_exp);
    endtask

    initial begin
        int n, s0, t0, jd;
        logic [DW-1:0] held;
        req_toggle_async = 1;
        #1 rst_main = 1;
        step(1);
        chk("rst_start", eng_start, 0);
        chk("rst_results", results, 0);
        chk("rst_valid", results_valid, 0);
        chk("rst_pending", pending_cnt, 0);
        chk("rst_jobs", jobs_done, 0);
        chk("rst_ovf", overflow_err, 0);
        chk("rst_tmo", timeout_err, 0);
        chk("rst_idle", idle, 1);
        step(3);
        rst_main = 0;
        step(12);
        chk("prime_pending", pending_cnt, 0);
        chk("prime_starts", starts, 0);
        chk("prime_idle", idle, 1);

        // single job, fixed data, latency checks
        fixed = 1;
        eng_delay = 10;
        toggle();
        wait_start(20, n);
        chk("start_latency", n - 1, SS + 2);
        step(1);
        chk("pending_after_launch", pending_cnt, 0);
        wait_valid(40);
        chk("result_latency", cyc - done_cyc, 2);
        chk("fixed_data", results, 80'h0005_0004_0003_0002_0001);
        take_result("single");
        ack();
        chk("ack_clears", results_valid, 0);
        fixed = 0;

        // overflow with the engine held busy, then drain under back-pressure
        busy_hold = 1;
        s0 = starts;
        for (int i = 0; i < 6; i++) begin
            toggle();
            step(4);
        end
        step(4);
        chk("ovf_pending", pending_cnt, QD);
        chk("ovf_flag", overflow_err, 1);
        chk("ovf_no_start", starts, s0);
        err_clr = 1;
        step(1);
        err_clr = 0;
        chk("ovf_cleared", overflow_err, 0);
        eng_delay = $urandom_range(1, 12);
        busy_hold = 0;
        for (int j = 0; j < QD; j++) begin
            wait_valid(60);
            take_result("drain");
            chk("drain_starts", starts, s0 + j + 1);
            step($urandom_range(0, 5));
            chk("backpressure", starts, s0 + j + 1);
            chk("drain_pending", pending_cnt, QD - 1 - j);
            eng_delay = $urandom_range(1, 12);
            ack();
        end
        chk("drain_idle", idle, 1);

        // watchdog expiry, then the queued job proceeds
        eng_hang = 1;
        eng_delay = 3;
        toggle();
        step(3);
        toggle();
        wait_start(20, n);
        t0 = cyc;
        jd = jobs_done;
        n = 0;
        while (!timeout_err && n < 40) begin
            step(1);
            n++;
        end
        chk("tmo_latency", cyc - t0, TO + 1);
        eng_hang = 0;
        eng_delay = $urandom_range(2, 8);
        chk("tmo_jobs", jobs_done, jd);
        wait_start(10, n);
        wait_valid(30);
        take_result("after_tmo");
        ack();
        chk("tmo_sticky", timeout_err, 1);
        err_clr = 1;
        step(1);
        err_clr = 0;
        chk("tmo_cleared", timeout_err, 0);

        // abort during WAIT with two pending; the late done must be ignored
        eng_delay = 14;
        s0 = starts;
        held = results;
        toggle();
        wait_start(20, n);
        toggle();
        step(3);
        toggle();
        step(6);
        chk("abort_pre_pending", pending_cnt, 2);
        chk("abort_pre_idle", idle, 0);
        abort = 1;
        step(1);
        abort = 0;
        chk("abort_pending", pending_cnt, 0);
        chk("abort_idle", idle, 1);
        step(12);
        chk("late_done_sent", exp_q.size(), 1);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        chk("abort_valid", results_valid, 0);
        chk("abort_results", results, held);
        chk("abort_jobs", jobs_done, jobs_exp);
        chk("abort_starts", starts, s0 + 1);

        // ack coinciding with the LATCH cycle: the new result stays valid
        eng_delay = $urandom_range(3, 10);
        toggle();
        wait_start(20, n);
        n = 0;
        while (!eng_done && n < 20) begin
            step(1);
            n++;
        end
        results_ack = 1;
        step(1);
        results_ack = 0;
        chk("latch_ack_valid", results_valid, 1);
        take_result("latch_ack");
        ack();
        chk("latch_ack_clear", results_valid, 0);

        // random bursts of jobs with random engine delay and consumer latency
        for (int it = 0; it < 4; it++) begin
            int k = $urandom_range(1, QD);
            eng_delay = $urandom_range(1, 12);
            for (int i = 0; i < k; i++) begin
                toggle();
                step(4);
            end
            for (int i = 0; i < k; i++) begin
                wait_valid(60);
                take_result("rand");
                step($urandom_range(0, 4));
                eng_delay = $urandom_range(1, 12);
                ack();
            end
        end
        step(2);
        chk("final_pending", pending_cnt, 0);
        chk("final_idle", idle, 1);
        chk("final_ovf", overflow_err, 0);
        chk("final_tmo", timeout_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
